// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Instruction fetch unit with an internal 2**AW x 32 program   |
// |               memory. It fetches words sequentially from address 0 and     |
// |               issues them to the datapath over a valid/ready handshake. It |
// |               stops on a halt word (bits [31:29] == 3'b111) or at the end  |
// |               of memory.                                                   |
// | Options     : FETCH_WRAP_EN - wrap pc to 0 after the last word instead of  |
// |               halting. The halt word is then the only exit.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   input  logic          ins_ready,
   output logic [31:0]   INS,
   output logic          ins_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted
);

   localparam int          c_DEPTH   = 2 ** AW;
   localparam logic [AW-1:0] c_PC_LAST = {AW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] w_pc_nxt;
   logic [31:0]   r_ins;
   logic [31:0]   w_ins_nxt;
   logic          r_valid;
   logic          w_valid_nxt;
   logic          w_mem_we;
   logic [31:0]   w_fetch_word;

   // Program memory is deliberately outside the reset domain so a program
   // loaded before reset survives it.
   logic [31:0]   r_mem [c_DEPTH];

   // Program memory write port; only honoured while the unit is not running.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   // State and datapath registers; reset aborts any fetch or issue at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_ins   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ins   <= w_ins_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Next-state and next-datapath logic for the fetch/issue sequence.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ins_nxt    = r_ins;
      w_valid_nxt  = r_valid;
      w_mem_we     = 1'b0;
      w_fetch_word = r_mem[r_pc];

      case (r_state)
         S_IDLE, S_HALT: begin
            // A write in the same cycle as start lands before the first
            // fetch, so that fetch sees the new contents.
            w_mem_we = prog_we;
            if (start) begin
               w_pc_nxt    = '0;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_fetch_word[31:29] == 3'b111) begin
               // Halt word is consumed here and never reaches the datapath.
               w_valid_nxt = 1'b0;
               w_state_nxt = S_HALT;
            end else begin
               w_ins_nxt   = w_fetch_word;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_valid && ins_ready) begin
               w_valid_nxt = 1'b0;
               if (r_pc != c_PC_LAST) begin
                  w_pc_nxt    = r_pc + 1'b1;
                  w_state_nxt = S_FETCH;
               end else begin
`ifdef FETCH_WRAP_EN
                  w_pc_nxt    = '0;
                  w_state_nxt = S_FETCH;
`else
                  // End of memory: stop with pc left on the last word.
                  w_state_nxt = S_HALT;
`endif
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign INS       = r_ins;
   assign ins_valid = r_valid;
   assign pc        = r_pc;
   assign busy      = (r_state == S_FETCH) || (r_state == S_ISSUE);
   assign halted    = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Scoreboard bench for instr_fetch_unit. The expected issue    |
// |               sequence is derived from a shadow copy of program memory    |
// |               on each start and compared against every accepted word.     |
// | Options     : FETCH_WRAP_EN - selects the wrap-around expectations.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

   localparam int AW = 4;
   localparam int c_DEPTH = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;
   logic          ins_ready;
   logic [31:0]   INS;
   logic          ins_valid;
   logic [AW-1:0] pc;
   logic          busy;
   logic          halted;

   instr_fetch_unit #(.AW(AW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .ins_ready (ins_ready),
      .INS       (INS),
      .ins_valid (ins_valid),
      .pc        (pc),
      .busy      (busy),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] m [c_DEPTH];
   logic [35:0] q [$];
   logic        exp_end_halt;
   logic [3:0]  exp_end_pc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a[3:0];
      prog_data = d;
      tick();
      prog_we   = 1'b0;
      m[a]      = d;
   endtask

   // Walk the shadow memory to build the issue sequence a start should produce.
   task automatic push_run(input int lim);
      int a = 0;
      exp_end_halt = 1'b0;
      while (q.size() < lim) begin
         if (m[a][31:29] == 3'b111) begin
            exp_end_halt = 1'b1;
            break;
         end
         q.push_back({a[3:0], m[a]});
         if (a == c_DEPTH - 1) begin
`ifdef FETCH_WRAP_EN
            a = 0;
`else
            exp_end_halt = 1'b1;
            break;
`endif
         end else begin
            a++;
         end
      end
      exp_end_pc = a[3:0];
   endtask

   task automatic do_start(input int lim);
      push_run(lim);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait for the scoreboard to drain, then check the final state of the run.
   task automatic finish_run(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_drained"}, q.size(), 0);
      ins_ready = 1'b0;
      if (exp_end_halt) begin
         n = 0;
         while (!halted && n < 20) begin
            tick();
            n++;
         end
         chk({tag, "_halted"}, halted, 1'b1);
         chk({tag, "_end_pc"}, pc, exp_end_pc);
         chk({tag, "_end_valid"}, ins_valid, 1'b0);
      end else begin
         chk({tag, "_still_busy"}, busy, 1'b1);
         reset = 1'b0;
         #2;
         reset = 1'b1;
         q.delete();
         tick();
      end
   endtask

   // Scoreboard: every accepted word must be the next expected one.
   always @(negedge clk) begin
      if (reset && ins_valid && ins_ready) begin
         chk("sb_nonempty", q.size() != 0, 1'b1);
         if (q.size() != 0) chk("issue_pc_ins", {pc, INS}, q.pop_front());
         chk("no_halt_word", INS[31:29] == 3'b111, 1'b0);
      end
   end

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; prog_we = 1'b0;
      prog_addr = '0; prog_data = '0; ins_ready = 1'b0;
      for (int i = 0; i < c_DEPTH; i++) m[i] = 32'hFFFF_FFFF;

      // Reset state
      tick(); tick();
      chk("rst_ins", INS, 32'h0);
      chk("rst_valid", ins_valid, 1'b0);
      chk("rst_pc", pc, 4'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);
      reset = 1'b1;
      tick();
      chk("idle_stays", busy, 1'b0);

      // Basic fetch, two-edge latency, halt word
      load(0, 32'h0422_1800);
      load(1, 32'hE000_0000);
      ins_ready = 1'b1;
      do_start(40);
      chk("lat_edge1_valid", ins_valid, 1'b0);
      chk("lat_edge1_busy", busy, 1'b1);
      tick();
      chk("lat_edge2_valid", ins_valid, 1'b1);
      chk("lat_edge2_ins", INS, 32'h0422_1800);
      chk("lat_edge2_pc", pc, 4'd0);
      finish_run("t1");

      // Back-pressure: held stable for five cycles
      load(0, 32'h1111_0000);
      load(1, 32'h2222_0001);
      load(2, 32'hE000_0002);
      ins_ready = 1'b0;
      do_start(40);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_ins", INS, 32'h1111_0000);
         chk("hold_pc", pc, 4'd0);
         chk("hold_valid", ins_valid, 1'b1);
         tick();
      end
      ins_ready = 1'b1;
      tick();
      chk("after_accept_pc", pc, 4'd1);
      chk("after_accept_valid", ins_valid, 1'b0);
      finish_run("t2");

      // Writes ignored while busy, start ignored while busy
      load(0, 32'h0000_00A0);
      load(1, 32'h0000_00A1);
      load(2, 32'h0000_00A2);
      load(3, 32'h0000_00A3);
      load(4, 32'hF000_0000);
      ins_ready = 1'b0;
      do_start(40);
      tick();
      prog_we = 1'b1; prog_addr = 4'd3; prog_data = 32'hDEAD_BEEF;
      tick();
      prog_we = 1'b0;
      ins_ready = 1'b1;
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_run("t3");

      // Full memory of non-halt words
      for (int i = 0; i < c_DEPTH; i++) load(i, 32'h1000_0000 + i * 32'h0001_0111);
      ins_ready = 1'b1;
      do_start(17);
      finish_run("t4");

      // Asynchronous reset mid-issue, then resume with memory intact
      ins_ready = 1'b0;
      do_start(17);
      n = 0;
      while (!ins_valid && n < 10) begin
         tick();
         n++;
      end
      chk("pre_rst_valid", ins_valid, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_ins", INS, 32'h0);
      chk("arst_valid", ins_valid, 1'b0);
      chk("arst_pc", pc, 4'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_halted", halted, 1'b0);
      q.delete();
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_idle", busy, 1'b0);
      ins_ready = 1'b1;
      do_start(17);
      finish_run("t5");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter AW, default 4, meaning instruction-memory address width (depth 2**AW words of 32 bits).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin execution from address 0.
REQ-005 SHALL have port prog_we  input  1  program-memory write enable.
REQ-006 SHALL have port prog_addr  input  AW  program-memory write address.
REQ-007 SHALL have port prog_data  input  32  program-memory write data.
REQ-008 SHALL have port ins_ready  input  1  downstream datapath accepts INS this cycle.
REQ-009 SHALL have port INS  output  32  registered instruction word to the datapath.
REQ-010 SHALL have port ins_valid  output  1  INS holds a valid instruction.
REQ-011 SHALL have port pc  output  AW  address of the word currently fetched or issued.
REQ-012 SHALL have port busy  output  1  high in FETCH or ISSUE.
REQ-013 SHALL have port halted  output  1  high in HALT.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, ISSUE, HALT.
REQ-015 SHALL write prog_data to mem[prog_addr] on a clock edge with prog_we=1 only in IDLE or HALT; writes in FETCH/ISSUE are ignored.
REQ-016 SHALL, on start=1 in IDLE or HALT, set pc=0 and enter FETCH on the next edge; start in FETCH/ISSUE is ignored.
REQ-017 SHALL, with simultaneous prog_we and start in IDLE/HALT, perform the write; the subsequent FETCH reads the updated contents.
REQ-018 SHALL, in FETCH, read mem[pc]: if bits [31:29]==3'b111 (halt word) enter HALT with ins_valid kept 0; otherwise load INS=mem[pc], set ins_valid=1, enter ISSUE.
REQ-019 SHALL give latency of two edges from start sampled to ins_valid=1 for the first word.
REQ-020 SHALL, in ISSUE, hold INS, pc and ins_valid stable until ins_valid&&ins_ready on an edge.
REQ-021 SHALL, on acceptance with pc < 2**AW-1, clear ins_valid, increment pc, enter FETCH (one instruction per two cycles maximum).
REQ-022 SHALL, on acceptance with pc == 2**AW-1, behave per REQ-029/REQ-030.
REQ-023 SHALL never issue the halt word to the datapath.
REQ-024 SHALL keep INS at its last value outside ISSUE (only ins_valid qualifies it).

Reset
REQ-025 SHALL, on reset=0, immediately force state=IDLE, pc=0, INS=0, ins_valid=0, busy=0, halted=0, independent of clk.
REQ-026 SHALL abort any fetch/issue in progress when reset asserts mid-operation; no partial transfer is completed after release.
REQ-027 SHALL NOT reset program-memory contents; contents survive reset.
REQ-028 SHALL leave IDLE only on start after reset deasserts.

Configuration
REQ-029 SHALL, with macro FETCH_WRAP_EN defined, wrap pc from 2**AW-1 to 0 on acceptance and continue in FETCH (halt word is the only exit).
REQ-030 SHALL, without FETCH_WRAP_EN, enter HALT on acceptance at pc == 2**AW-1, leaving pc at 2**AW-1.

Verification
REQ-031 SHALL cover: load mem[0]=32'h04221800, mem[1]=32'hE0000000, start, ins_ready=1 -> ins_valid high 2 edges after start with INS=32'h04221800, pc=0; then HALT with halted=1, halt word never valid.
REQ-032 SHALL cover: ins_ready=0 for 5 cycles with word at pc=0 -> INS, pc, ins_valid constant for all 5 cycles; pc=1 FETCH after ready=1.
REQ-033 SHALL cover: all 16 words non-halt (AW=4), ins_ready=1 -> 16 issues; without FETCH_WRAP_EN halted=1 with pc=15; with it pc returns to 0 and mem[0] reissued.
REQ-034 SHALL cover: prog_we=1 addr 3 data 32'hDEADBEEF during ISSUE -> mem[3] unchanged on later fetch.
REQ-035 SHALL cover: reset=0 asserted between edges while ins_valid=1 -> all outputs zero immediately; after release and start, fetch resumes at pc=0 with memory intact.
REQ-036 SHALL cover: start pulsed while busy -> ignored, pc sequence unaffected.
